// File: rtl/calc_seq_unit.sv
// calc_seq_unit: integer execute-stage calculation unit.
// Single-cycle add/sub/shift/logic/compare ops and iterative (one bit per
// cycle) multiply, divide and remainder, with valid/ready handshakes on both
// sides so the pipeline can stall while an iterative op runs.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous, active-high
//   in_valid   operation request
//   in_ready   unit can accept a request this cycle
//   opt        operation select (0-7 alu, 8/9 mul, A-D div/rem, E/F compare)
//   a, b       operands (shift amount is b[$clog2(WIDTH)-1:0])
//   out_valid  result available
//   out_ready  consumer takes the result this cycle
//   result     operation result, held while out_valid && !out_ready
//   busy       iterative operation in progress
module calc_seq_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = SW + 1;
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] result_next;
    logic [3:0]       op_q, op_next;
    logic [CW-1:0]    cnt, cnt_next;
    // acc: mul -> {partial product high, multiplier shifting out};
    //      div -> {partial remainder, dividend shifting out / quotient in}
    logic [AW-1:0]    acc, acc_next;
    logic [WIDTH-1:0] opb, opb_next;
    logic             neg_q, neg_q_next;
    logic             neg_r, neg_r_next;
    logic             dz, dz_next;

    logic             accept;
    logic             is_iter;
    logic             is_signed_div;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu;
    logic [AW-1:0]    step;
    logic [WIDTH-1:0] fixup;

    assign in_ready  = !reset && (state == IDLE || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC);

    // Operand decode for a newly accepted request
    assign is_iter       = (opt >= 4'h8) && (opt <= 4'hD);
    assign is_signed_div = (opt == 4'hC) || (opt == 4'hD);
    assign a_neg         = is_signed_div && a[WIDTH-1];
    assign b_neg         = is_signed_div && b[WIDTH-1];
    assign abs_a         = a_neg ? WIDTH'(-a) : a;
    assign abs_b         = b_neg ? WIDTH'(-b) : b;
    assign shamt         = b[SW-1:0];

    // Single-cycle operations
    always_comb begin
        alu = '0;
        case (opt)
            4'h0:    alu = a + b;
            4'h1:    alu = a - b;
            4'h2:    alu = a << shamt;
            4'h3:    alu = a >> shamt;
            4'h4:    alu = $unsigned($signed(a) >>> shamt);
            4'h5:    alu = a & b;
            4'h6:    alu = a | b;
            4'h7:    alu = a ^ b;
            4'hE:    alu = WIDTH'($signed(a) < $signed(b));
            4'hF:    alu = WIDTH'(a < b);
            default: alu = '0;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        logic [WIDTH:0] sum;
        logic [WIDTH:0] rtmp;
        logic [WIDTH:0] diff;
        sum  = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        rtmp = {acc[AW-1:WIDTH], acc[WIDTH-1]};
        diff = rtmp - {1'b0, opb};
        if (op_q[3:1] == 3'b100) begin
            step = {sum, acc[WIDTH-1:1]};
        end else if (diff[WIDTH]) begin
            step = {rtmp[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Final select and sign fix-up, applied to the last iteration's output.
    // Remainder of a zero divisor is already |a| and takes a's sign, so only
    // the quotient needs an explicit override.
    always_comb begin
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        q     = step[WIDTH-1:0];
        r     = step[AW-1:WIDTH];
        fixup = '0;
        case (op_q)
            4'h8:    fixup = q;
            4'h9:    fixup = r;
            4'hA:    fixup = dz ? '1 : q;
            4'hB:    fixup = r;
            4'hC:    fixup = dz ? '1 : (neg_q ? WIDTH'(-q) : q);
            4'hD:    fixup = neg_r ? WIDTH'(-r) : r;
            default: fixup = '0;
        endcase
    end

    // Next-state and datapath register inputs
    always_comb begin
        state_next  = state;
        result_next = result;
        op_next     = op_q;
        cnt_next    = cnt;
        acc_next    = acc;
        opb_next    = opb;
        neg_q_next  = neg_q;
        neg_r_next  = neg_r;
        dz_next     = dz;

        case (state)
            IDLE: ;
            CALC: begin
                cnt_next = cnt - CW'(1);
                acc_next = step;
                if (cnt == CW'(1)) begin
                    result_next = fixup;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (out_ready && !in_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (accept) begin
            op_next = opt;
            if (is_iter) begin
                cnt_next   = CW'(WIDTH);
                acc_next   = {{WIDTH{1'b0}}, (opt[3:1] == 3'b100) ? a : abs_a};
                opb_next   = (opt[3:1] == 3'b100) ? b : abs_b;
                neg_q_next = a_neg ^ b_neg;
                neg_r_next = a_neg;
                dz_next    = (b == '0);
                state_next = CALC;
            end else begin
                result_next = alu;
                state_next  = DONE;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            result <= '0;
            op_q   <= '0;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else begin
            state  <= state_next;
            result <= result_next;
            op_q   <= op_next;
            cnt    <= cnt_next;
            acc    <= acc_next;
            opb    <= opb_next;
            neg_q  <= neg_q_next;
            neg_r  <= neg_r_next;
            dz     <= dz_next;
        end
    end

endmodule
